// File: rtl/uart_reg_write_bridge.sv
// UART (8N1) command receiver that turns checksummed A5/addr/data/csum packets
// into single-cycle register writes for the LED register peripheral.
module uart_reg_write_bridge #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         TIMEOUT_CLKS = 17360,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic       write_enable,
    output logic [7:0] write_address,
    output logic [7:0] write_data,
    output logic       frame_error,
    output logic       pkt_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_WAIT_SYNC, P_GET_ADDR, P_GET_DATA, P_GET_CSUM} p_state_t;

    logic          r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t     r_rx_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_byte_valid;

    p_state_t      r_pstate;
    logic [7:0]    r_addr, r_data;
    logic [TW-1:0] r_idle_cnt;
    logic          r_chk_pend, r_chk_ok;
    logic [7:0]    w_csum_exp;

    // r_rx_prev is a third stage used only for falling-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state   <= RX_IDLE;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            frame_error  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_clk_cnt  <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (r_clk_cnt == HALF_M1) begin
                        r_clk_cnt  <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt  <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rx_sync) r_byte_valid <= 1'b1;
                        else           frame_error  <= 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign w_csum_exp = r_addr + r_data;
    assign busy       = (r_pstate != P_WAIT_SYNC);

    // Checksum verdict is registered first, then drives the output strobes one edge later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pstate      <= P_WAIT_SYNC;
            r_addr        <= '0;
            r_data        <= '0;
            r_idle_cnt    <= '0;
            r_chk_pend    <= 1'b0;
            r_chk_ok      <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            pkt_error     <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            pkt_error    <= 1'b0;
            r_chk_pend   <= 1'b0;
            if (r_chk_pend) begin
                if (r_chk_ok) begin
                    write_enable  <= 1'b1;
                    write_address <= r_addr;
                    write_data    <= r_data;
                end else begin
                    pkt_error <= 1'b1;
                end
            end
            if (frame_error) begin
                r_pstate   <= P_WAIT_SYNC;
                r_idle_cnt <= '0;
            end else if (r_byte_valid) begin
                r_idle_cnt <= '0;
                case (r_pstate)
                    P_WAIT_SYNC: if (r_shift == SYNC_BYTE) r_pstate <= P_GET_ADDR;
                    P_GET_ADDR: begin
                        r_addr   <= r_shift;
                        r_pstate <= P_GET_DATA;
                    end
                    P_GET_DATA: begin
                        r_data   <= r_shift;
                        r_pstate <= P_GET_CSUM;
                    end
                    P_GET_CSUM: begin
                        r_chk_pend <= 1'b1;
                        r_chk_ok   <= (r_shift == w_csum_exp);
                        r_pstate   <= P_WAIT_SYNC;
                    end
                    default: r_pstate <= P_WAIT_SYNC;
                endcase
            end else if (r_pstate != P_WAIT_SYNC) begin
                if (r_idle_cnt == TO_M1) begin
                    r_pstate   <= P_WAIT_SYNC;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_reg_write_bridge.sv
// Scoreboard bench for uart_reg_write_bridge: stimulus queues expected strobes,
// a negedge monitor pops and compares them, including exact strobe cycle.
module tb_uart_reg_write_bridge;
    localparam int CPB = 16;
    localparam int TO  = 400;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       write_enable, frame_error, pkt_error, busy;
    logic [7:0] write_address, write_data;

    uart_reg_write_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .frame_error(frame_error), .pkt_error(pkt_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // kind: 0 = write, 1 = pkt_error, 2 = frame_error
    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } ev_t;
    ev_t q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at the negedge where the byte's start bit is driven.
    // Stop sample lands 155 edges later; write/pkt_error strobe 2 edges after that.
    task automatic expect_ev(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        e.c    = cyc + ((kind == 2) ? 155 : 157);
        q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c, input int kind);
        send_byte(8'hA5, 1'b1);
        send_byte(a, 1'b1);
        send_byte(d, 1'b1);
        if (kind >= 0) expect_ev(kind, a, d);
        send_byte(c, (kind != 2));
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  kind;
        if (reset_n && (write_enable || pkt_error || frame_error)) begin
            kind = write_enable ? 0 : (pkt_error ? 1 : 2);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got kind=%0d at cyc %0d expected none", kind, cyc);
            end else begin
                e = q.pop_front();
                check("strobe_kind", kind, e.kind);
                check("strobe_cycle", cyc, e.c);
                if (kind == 0) begin
                    check("wr_addr", write_address, e.a);
                    check("wr_data", write_data, e.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_we", write_enable, 0);
        check("rst_wa", write_address, 0);
        check("rst_wd", write_data, 0);
        check("rst_fe", frame_error, 0);
        check("rst_pe", pkt_error, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // basic packet
        send_pkt(8'h01, 8'h01, 8'h02, 0);
        repeat (10) @(negedge clk);
        check("t1_wa", write_address, 8'h01);
        check("t1_wd", write_data, 8'h01);
        check("t1_busy", busy, 0);

        // back-to-back packets, outputs held in between
        send_pkt(8'h02, 8'h3C, 8'h3E, 0);
        check("t2_hold_wa", write_address, 8'h02);
        check("t2_hold_wd", write_data, 8'h3C);
        send_pkt(8'h03, 8'hC3, 8'hC6, 0);
        repeat (10) @(negedge clk);
        check("t2_wa", write_address, 8'h03);
        check("t2_wd", write_data, 8'hC3);

        // bad checksum
        send_pkt(8'h02, 8'h3C, 8'h00, 1);
        repeat (10) @(negedge clk);
        check("t3_wa_held", write_address, 8'h03);
        check("t3_wd_held", write_data, 8'hC3);
        check("t3_busy", busy, 0);

        // leading junk bytes ignored
        send_byte(8'h5A, 1'b1);
        send_byte(8'h11, 1'b1);
        check("t4_busy_junk", busy, 0);
        send_byte(8'hA5, 1'b1);
        check("t4_busy_sync", busy, 1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        expect_ev(0, 8'h01, 8'h01);
        send_byte(8'h02, 1'b1);
        repeat (10) @(negedge clk);

        // framing error on checksum byte, then recovery
        send_pkt(8'h01, 8'h01, 8'h02, 2);
        repeat (2 * CPB) @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_wa_held", write_address, 8'h01);
        send_pkt(8'h03, 8'h55, 8'h58, 0);
        repeat (10) @(negedge clk);
        check("t5_wa", write_address, 8'h03);
        check("t5_wd", write_data, 8'h55);

        // inter-byte timeout
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        check("t6_busy_mid", busy, 1);
        repeat (TO - 50) @(negedge clk);
        check("t6_busy_before_to", busy, 1);
        repeat (55) @(negedge clk);
        check("t6_busy_after_to", busy, 0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h3E, 1'b1);
        repeat (20) @(negedge clk);
        check("t6_wa_held", write_address, 8'h03);
        check("t6_wd_held", write_data, 8'h55);

        // asynchronous reset in the middle of a byte
        send_byte(8'hA5, 1'b1);
        uart_rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t7_we", write_enable, 0);
        check("t7_wa", write_address, 0);
        check("t7_wd", write_data, 0);
        check("t7_fe", frame_error, 0);
        check("t7_pe", pkt_error, 0);
        check("t7_busy", busy, 0);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_pkt(8'h02, 8'hF0, 8'hF2, 0);
        repeat (10) @(negedge clk);
        check("t7_post_wa", write_address, 8'h02);
        check("t7_post_wd", write_data, 8'hF0);

        repeat (20) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
